// File: rtl/ip_parser.sv
// -----------------------------------------------------------------------------
// ip_parser
// Second stage of the Ethernet receive path. Takes the byte stream that follows
// the Ethernet header, checks the IPv4 header (including options) and forwards
// only the IP payload of accepted packets. Ethernet padding and FCS bytes after
// the payload are discarded. Rejected packets are consumed silently and
// signalled with a one-cycle pkt_dropped pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_axis_*          input byte stream; tuser[17:2] ethertype, [1:0] MAC match
//   m_axis_*          IP payload stream; tuser[31:0] src IP, [47:32] payload
//                     length in bytes, [48] destination was broadcast
//   pkt_dropped       1-cycle pulse per rejected or aborted packet
//   pkt_truncated     1-cycle pulse when a frame ends before the payload length
// -----------------------------------------------------------------------------
module ip_parser #(
    parameter int          DATA_WIDTH     = 8,
    parameter logic [31:0] TARGET_IP_ADDR = 32'hC0A8010A,
    parameter bit          ACCEPT_BCAST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [17:0]           s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [48:0]           m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  pkt_dropped,
    output logic                  pkt_truncated
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_OPTIONS, S_PAYLOAD, S_PAD, S_DROP
    } state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_idx;        // index of the header byte currently presented
    logic [3:0]  r_ver, r_ihl;
    logic [15:0] r_total_len;
    logic [13:0] r_frag;       // MF flag + fragment offset
    logic [31:0] r_src, r_dst;
    logic [7:0]  r_hi;         // high byte of the checksum word in progress
    logic [15:0] r_csum;
    logic [17:0] r_user_in;
    logic [15:0] r_pay_cnt;
    logic [48:0] r_m_tuser;
    logic        r_dropped, r_trunc;

    logic        w_xfer;
    logic [16:0] w_sum17;
    logic [15:0] w_csum_next, w_csum_final;
    logic [31:0] w_dst;
    logic [15:0] w_hdr_len, w_len;
    logic        w_hdr_end, w_hdr_ok, w_bcast;

    assign w_xfer = s_axis_tvalid & s_axis_tready;

    // One's-complement add of the current big-endian word with end-around carry.
    // The folded result cannot overflow 16 bits (max 0x1FFFE -> 0xFFFF).
    assign w_sum17      = {1'b0, r_csum} + {1'b0, r_hi, s_axis_tdata};
    assign w_csum_next  = w_sum17[15:0] + {15'd0, w_sum17[16]};
    assign w_csum_final = r_idx[0] ? w_csum_next : r_csum;

    // The last destination byte may be the byte being accepted right now.
    assign w_dst     = (r_idx == 6'd19) ? {r_dst[23:0], s_axis_tdata} : r_dst;
    assign w_hdr_len = {10'd0, r_ihl, 2'b00};
    assign w_len     = r_total_len - w_hdr_len;
    assign w_bcast   = (w_dst == 32'hFFFFFFFF);

    // With IHL<5 the header is still judged at byte 19 and then fails the IHL check.
    assign w_hdr_end = ((r_idx == 6'd19) && (r_ihl <= 4'd5)) ||
                       ((r_idx > 6'd19) && (r_idx == ({r_ihl, 2'b00} - 6'd1)));

    assign w_hdr_ok = (r_user_in[17:2] == 16'h0800) && (r_user_in[1:0] != 2'b00) &&
                      (r_ver == 4'd4) && (r_ihl >= 4'd5) &&
                      (w_csum_final == 16'hFFFF) && (r_frag == 14'd0) &&
                      (r_total_len >= w_hdr_len) &&
                      ((w_dst == TARGET_IP_ADDR) || (ACCEPT_BCAST && w_bcast));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // A one-byte frame cannot hold a header; it is dropped in place.
                if (w_xfer && !s_axis_tlast) w_next = S_HEADER;
            end
            S_HEADER, S_OPTIONS: begin
                if (w_xfer) begin
                    if (s_axis_tlast)       w_next = S_IDLE;
                    else if (w_hdr_end)     w_next = !w_hdr_ok ? S_DROP :
                                                     (w_len == 16'd0) ? S_PAD : S_PAYLOAD;
                    else if (r_idx == 6'd19) w_next = S_OPTIONS;
                end
            end
            S_PAYLOAD: begin
                if (w_xfer) begin
                    if (s_axis_tlast)               w_next = S_IDLE;
                    else if (r_pay_cnt == 16'd1)    w_next = S_PAD;
                end
            end
            S_PAD, S_DROP: begin
                if (w_xfer && s_axis_tlast) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: payload is a zero-latency pass-through with backpressure
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        if (r_state == S_PAYLOAD) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = (r_pay_cnt == 16'd1) | s_axis_tlast;
        end
    end

    assign m_axis_tuser  = r_m_tuser;
    assign pkt_dropped   = r_dropped;
    assign pkt_truncated = r_trunc;

    // Header capture, checksum, payload counter and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_ver       <= '0;
            r_ihl       <= '0;
            r_total_len <= '0;
            r_frag      <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_user_in   <= '0;
            r_pay_cnt   <= '0;
            r_m_tuser   <= '0;
            r_dropped   <= 1'b0;
            r_trunc     <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            r_trunc   <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        r_idx     <= 6'd1;
                        r_ver     <= s_axis_tdata[7:4];
                        r_ihl     <= s_axis_tdata[3:0];
                        r_hi      <= s_axis_tdata;
                        r_csum    <= '0;
                        r_user_in <= s_axis_tuser;
                        if (s_axis_tlast) r_dropped <= 1'b1;
                    end
                    S_HEADER, S_OPTIONS: begin
                        r_idx <= r_idx + 6'd1;
                        if (!r_idx[0]) r_hi   <= s_axis_tdata;
                        else           r_csum <= w_csum_next;
                        case (r_idx)
                            6'd2:  r_total_len[15:8] <= s_axis_tdata;
                            6'd3:  r_total_len[7:0]  <= s_axis_tdata;
                            6'd6:  r_frag[13:8]      <= s_axis_tdata[5:0];
                            6'd7:  r_frag[7:0]       <= s_axis_tdata;
                            6'd12, 6'd13, 6'd14, 6'd15:
                                   r_src <= {r_src[23:0], s_axis_tdata};
                            6'd16, 6'd17, 6'd18, 6'd19:
                                   r_dst <= {r_dst[23:0], s_axis_tdata};
                            default: ;
                        endcase
                        if (s_axis_tlast) begin
                            r_dropped <= 1'b1;
                        end else if (w_hdr_end) begin
                            if (!w_hdr_ok) begin
                                r_dropped <= 1'b1;
                            end else begin
                                r_m_tuser <= {w_bcast, w_len, r_src};
                                r_pay_cnt <= w_len;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        r_pay_cnt <= r_pay_cnt - 16'd1;
                        if (s_axis_tlast && (r_pay_cnt > 16'd1)) r_trunc <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ip_parser.sv
module tb_ip_parser;

    localparam logic [31:0] SRC  = 32'hC0A80164;
    localparam logic [31:0] DST  = 32'hC0A8010A;
    localparam logic [17:0] U_OK = {16'h0800, 2'b01};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [17:0] s_tuser = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [48:0] m_tuser;
    logic        m_tready = 1'b1;
    logic        pkt_dropped;
    logic        pkt_truncated;

    always #5 clk = ~clk;

    ip_parser #(
        .DATA_WIDTH(8),
        .TARGET_IP_ADDR(DST),
        .ACCEPT_BCAST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser),
        .m_axis_tready(m_tready),
        .pkt_dropped(pkt_dropped),
        .pkt_truncated(pkt_truncated)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx_d[$];
    bit          tx_l[$];
    logic [17:0] tx_u[$];
    logic [7:0]  exp_d[$];
    bit          exp_l[$];
    logic [7:0]  rx_d[$];
    bit          rx_l[$];
    int          n_drop = 0;
    int          n_trunc = 0;
    bit          throttle = 1'b0;

    // Observe handshakes and pulses half a cycle before the edge that uses them
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            rx_d.push_back(m_tdata);
            rx_l.push_back(m_tlast);
        end
        if (pkt_dropped)   n_drop++;
        if (pkt_truncated) n_trunc++;
    end

    always @(posedge clk) begin
        #1;
        m_tready = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Build one frame: IPv4 header (+NOP options), payload 0x30+i, pad 0xEE.
    // corrupt >= 0 flips bit 0 of that header byte after the checksum is set;
    // cut > 0 ends the frame after that many bytes.
    task automatic build(input logic [17:0] user, input int ihl, input int tot,
                         input logic [31:0] dst, input int pay_n, input int pad_n,
                         input int corrupt, input int cut, input bit accept);
        logic [7:0]  h[60];
        logic [7:0]  f[$];
        logic [15:0] c;
        int          sum;
        int          n;
        int          nout;
        for (int i = 0; i < 60; i++) h[i] = 8'h00;
        h[0] = 8'h40 | 8'(ihl);
        h[2] = 8'(tot >> 8);
        h[3] = 8'(tot);
        h[4] = 8'h12;
        h[5] = 8'h34;
        h[8] = 8'h40;
        h[9] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            h[12+i] = 8'(SRC >> (24 - 8*i));
            h[16+i] = 8'(dst >> (24 - 8*i));
        end
        for (int i = 20; i < ihl*4; i++) h[i] = 8'h01;
        sum = 0;
        for (int i = 0; i < ihl*4; i += 2) begin
            sum = sum + int'({h[i], h[i+1]});
            sum = (sum & 32'hFFFF) + (sum >>> 16);
        end
        c = ~16'(sum);
        h[10] = c[15:8];
        h[11] = c[7:0];
        if (corrupt >= 0) h[corrupt] = h[corrupt] ^ 8'h01;
        for (int i = 0; i < ihl*4; i++) f.push_back(h[i]);
        for (int i = 0; i < pay_n; i++) f.push_back(8'h30 + 8'(i));
        for (int i = 0; i < pad_n; i++) f.push_back(8'hEE);
        n = (cut > 0) ? cut : f.size();
        for (int i = 0; i < n; i++) begin
            tx_d.push_back(f[i]);
            tx_l.push_back(i == n - 1);
            tx_u.push_back(user);
        end
        if (accept) begin
            nout = tot - ihl*4;
            if (nout > pay_n) nout = pay_n;
            for (int i = 0; i < nout; i++) begin
                exp_d.push_back(8'h30 + 8'(i));
                exp_l.push_back(i == nout - 1);
            end
        end
    endtask

    task automatic send_all();
        int n;
        while (tx_d.size() > 0) begin
            if (throttle) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_tdata  = tx_d.pop_front();
            s_tlast  = tx_l.pop_front();
            s_tuser  = tx_u.pop_front();
            s_tvalid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                n++;
                if (n > 2000) begin
                    $display("FAIL stall: s_axis_tready low for %0d cycles, required 1", n);
                    $fatal(1, "input stalled");
                end
            end
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int exp_drop, input int exp_trunc);
        n_drop  = 0;
        n_trunc = 0;
        rx_d.delete();
        rx_l.delete();
        send_all();
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_beats"}, 64'(rx_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(rx_d[i]), 64'(exp_d[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(rx_l[i]), 64'(exp_l[i]));
        end
        chk({tag, "_dropped"}, 64'(n_drop), 64'(exp_drop));
        chk({tag, "_truncated"}, 64'(n_trunc), 64'(exp_trunc));
        exp_d.delete();
        exp_l.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tuser", 64'(m_tuser), 64'd0);
        chk("rst_dropped", 64'(pkt_dropped), 64'd0);
        chk("rst_truncated", 64'(pkt_truncated), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;

        // Plain UDP packet: 20 hdr + 8 payload + 32 pad = 60 bytes
        build(U_OK, 5, 28, DST, 8, 32, -1, 0, 1'b1);
        run("t1", 0, 0);
        chk("t1_tuser", 64'(m_tuser), 64'({1'b0, 16'd8, SRC}));

        // Corrupted TTL byte breaks the checksum
        build(U_OK, 5, 28, DST, 8, 32, 8, 0, 1'b0);
        run("t2", 1, 0);

        // IHL=6: four option bytes consumed, 10 payload bytes
        build(U_OK, 6, 34, DST, 10, 26, -1, 0, 1'b1);
        run("t3", 0, 0);
        chk("t3_tuser", 64'(m_tuser), 64'({1'b0, 16'd10, SRC}));

        build({16'h86DD, 2'b01}, 5, 28, DST, 8, 32, -1, 0, 1'b0);
        run("t4_ethertype", 1, 0);
        build({16'h0800, 2'b00}, 5, 28, DST, 8, 32, -1, 0, 1'b0);
        run("t4_nomac", 1, 0);
        build(U_OK, 5, 28, 32'hC0A8010B, 8, 32, -1, 0, 1'b0);
        run("t4_otherdst", 1, 0);
        build({16'h0800, 2'b10}, 5, 28, 32'hFFFFFFFF, 8, 32, -1, 0, 1'b1);
        run("t4_bcast", 0, 0);
        chk("t4_bcast_tuser", 64'(m_tuser), 64'({1'b1, 16'd8, SRC}));

        // total_len=120 (payload 100) but the frame ends after 30 payload bytes
        build(U_OK, 5, 120, DST, 30, 0, -1, 0, 1'b1);
        run("t5_trunc", 0, 1);
        chk("t5_trunc_tuser", 64'(m_tuser), 64'({1'b0, 16'd100, SRC}));

        // Frame ends inside the header
        build(U_OK, 5, 28, DST, 8, 32, -1, 10, 1'b0);
        run("t5_hdrlast", 1, 0);

        // Zero-length payload: nothing emitted, padding swallowed
        build(U_OK, 5, 20, DST, 0, 40, -1, 0, 1'b1);
        run("t5_zero", 0, 0);
        chk("t5_zero_tuser", 64'(m_tuser), 64'({1'b0, 16'd0, SRC}));

        // Throttled on both sides, then back-to-back frames
        throttle = 1'b1;
        build(U_OK, 5, 28, DST, 8, 32, -1, 0, 1'b1);
        run("t6", 0, 0);
        build(U_OK, 5, 28, DST, 8, 32, -1, 0, 1'b1);
        build(U_OK, 5, 28, DST, 8, 32, 8, 0, 1'b0);
        build(U_OK, 6, 34, DST, 10, 26, -1, 0, 1'b1);
        run("t6_b2b", 1, 0);
        chk("t6_b2b_tuser", 64'(m_tuser), 64'({1'b0, 16'd10, SRC}));
        throttle = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
